// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit.
// The slave modport is the unit's view; the master modport is the driver's view.
interface logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic             err;

  modport slave (
    input  in_valid, op, a, b, acc_clr, out_ready,
    output in_ready, out_valid, y, zero, parity, err
  );

  modport master (
    output in_valid, op, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, y, zero, parity, err
  );
endinterface

// File: rtl/logic_unit.sv
// One-deep registered bitwise logic unit with valid/ready handshake on both sides.
// Define LOGIC_UNIT_ACC_EN to turn op 111 into ACC-AND against an internal accumulator.
module logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  logic_unit_if.slave bus
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             err_q, err_d;
  logic             in_xfer;
  logic [WIDTH-1:0] res;
  logic             res_err;

`ifdef LOGIC_UNIT_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = bus.acc_clr;
`endif

  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.err       = err_q;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (bus.op)
      3'b000: res = bus.a & bus.b;
      3'b001: res = bus.a | bus.b;
      3'b010: res = bus.a ^ bus.b;
      3'b011: res = ~(bus.a & bus.b);
      3'b100: res = ~(bus.a | bus.b);
      3'b101: res = ~(bus.a ^ bus.b);
      3'b110: res = ~bus.a;
      3'b111: begin
`ifdef LOGIC_UNIT_ACC_EN
        res = acc_q & bus.a;
`else
        res_err = 1'b1;
`endif
      end
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    y_d      = y_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    err_d    = err_q;
    if (in_xfer) begin
      valid_d  = 1'b1;
      y_d      = res;
      zero_d   = (res == '0);
      parity_d = ^res;
      err_d    = res_err;
    end else if (bus.out_ready) begin
      valid_d  = 1'b0;
    end
  end

`ifdef LOGIC_UNIT_ACC_EN
  // A clear request overrides a coincident ACC-AND update; y still sees the old value.
  always_comb begin
    acc_d = acc_q;
    if (bus.acc_clr) begin
      acc_d = '1;
    end else if (in_xfer && bus.op == 3'b111) begin
      acc_d = acc_q & bus.a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '1;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      y_q      <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      y_q      <= y_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit at WIDTH=4: directed scenarios plus a randomized
// run against a transaction-level model of the handshake and operation table.
module tb_logic_unit;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic_unit_if #(.WIDTH(W)) bus ();

  logic_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  logic         m_valid;
  logic [W-1:0] m_y;
  logic         m_err;
  logic [W-1:0] m_acc;

  function automatic logic [W-1:0] ref_y(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] acc);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: begin
`ifdef LOGIC_UNIT_ACC_EN
        return acc & a;
`else
        return '0;
`endif
      end
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op);
`ifdef LOGIC_UNIT_ACC_EN
    return 1'b0;
`else
    return op == 3'd7;
`endif
  endfunction

  function automatic logic [7:0] obs();
    return {bus.out_valid, bus.y, bus.zero, bus.parity, bus.err};
  endfunction

  function automatic logic [7:0] pack_exp(input logic v, input logic [W-1:0] y, input logic e);
    return {v, y, (y == 0), ($countones(y) % 2 == 1), e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.op       = 3'd0;
    bus.a        = '0;
    bus.b        = '0;
    bus.acc_clr  = 1'b0;
    bus.out_ready = 1'b0;
    #22;
    n_checks++;
    if (obs() !== 8'b0_0000_100) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", obs(), 8'b0_0000_100);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.a = 4'b1010; bus.b = 4'b1100; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (obs() !== 8'b1_1000_010) begin
      n_fail++;
      $display("FAIL basic_and: got %b expected %b", obs(), 8'b1_1000_010);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: out_valid got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [3] = '{3'b001, 3'b010, 3'b011};
    bus.a = 4'b0101; bus.b = 4'b1010; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.op = ops[i];
      tick();
      n_checks++;
      if (obs() !== 8'b1_1111_000) begin
        n_fail++;
        $display("FAIL b2b_op%0d: got %b expected %b", ops[i], obs(), 8'b1_1111_000);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.a = 4'b1111; bus.b = 4'b0011; bus.out_ready = 1'b0;
    tick();
    bus.op = 3'b010; bus.a = 4'b1100; bus.b = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
      end
      tick();
      n_checks++;
      if (obs() !== 8'b1_0011_000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %b expected %b", i, obs(), 8'b1_0011_000);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.y !== 4'b0011) begin
      n_fail++;
      $display("FAIL release_first: in_ready %b y %b expected 1 0011", bus.in_ready, bus.y);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (obs() !== 8'b1_1010_000) begin
      n_fail++;
      $display("FAIL release_pending: got %b expected %b", obs(), 8'b1_1010_000);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_drain: out_valid got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_nor();
    bus.in_valid = 1'b1; bus.op = 3'b100; bus.a = 4'b1111; bus.b = 4'b0000; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (obs() !== 8'b1_0000_100) begin
      n_fail++;
      $display("FAIL nor_zero: got %b expected %b", obs(), 8'b1_0000_100);
    end
    tick();
  endtask

  task automatic test_op7();
`ifdef LOGIC_UNIT_ACC_EN
    logic [W-1:0] av [4] = '{4'b1110, 4'b0111, 4'b0011, 4'b1010};
    logic [W-1:0] ev [4] = '{4'b1110, 4'b0110, 4'b0011, 4'b1010};
    bus.op = 3'b111; bus.b = 4'b0000; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.in_valid = 1'b0; bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
      end
      if (i == 3) begin
        // clear coinciding with an ACC-AND: old acc (0011) used, clear wins
        bus.in_valid = 1'b1; bus.a = 4'b0101; bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
        n_checks++;
        if (obs() !== pack_exp(1'b1, 4'b0001, 1'b0)) begin
          n_fail++;
          $display("FAIL acc_clr_collide: got %b expected %b", obs(), pack_exp(1'b1, 4'b0001, 1'b0));
        end
      end
      bus.in_valid = 1'b1; bus.a = av[i];
      tick();
      n_checks++;
      if (obs() !== pack_exp(1'b1, ev[i], 1'b0)) begin
        n_fail++;
        $display("FAIL acc_and[%0d]: got %b expected %b", i, obs(), pack_exp(1'b1, ev[i], 1'b0));
      end
    end
    bus.in_valid = 1'b0; bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
`else
    bus.in_valid = 1'b1; bus.op = 3'b111; bus.a = 4'b1110; bus.b = 4'b0110;
    bus.acc_clr = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.acc_clr = 1'b0;
    n_checks++;
    if (obs() !== 8'b1_0000_101) begin
      n_fail++;
      $display("FAIL op7_illegal: got %b expected %b", obs(), 8'b1_0000_101);
    end
    tick();
`endif
  endtask

  task automatic test_random();
    logic exp_ready;
    logic xfer;
    m_valid = 1'b0; m_y = bus.y; m_err = bus.err; m_acc = '1;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.op        = 3'($urandom_range(0, 7));
      bus.a         = 4'($urandom);
      bus.b         = 4'($urandom);
      bus.acc_clr   = ($urandom_range(0, 7) == 0);
      #1;
      exp_ready = !m_valid || bus.out_ready;
      n_checks++;
      if (bus.in_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL rand_in_ready[%0d]: got %b expected %b", i, bus.in_ready, exp_ready);
      end
      xfer = bus.in_valid && exp_ready;
      if (xfer) begin
        m_y     = ref_y(bus.op, bus.a, bus.b, m_acc);
        m_err   = ref_err(bus.op);
        m_valid = 1'b1;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
`ifdef LOGIC_UNIT_ACC_EN
      if (bus.acc_clr) m_acc = '1;
      else if (xfer && bus.op == 3'd7) m_acc = m_acc & bus.a;
`endif
      tick();
      n_checks++;
      if (obs() !== pack_exp(m_valid, m_y, m_err)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got %b expected %b", i, obs(), pack_exp(m_valid, m_y, m_err));
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.acc_clr = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.in_valid = 1'b1; bus.op = 3'b001; bus.a = 4'b1001; bus.b = 4'b0110; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (obs() !== 8'b1_1111_000) begin
      n_fail++;
      $display("FAIL pre_reset_hold: got %b expected %b", obs(), 8'b1_1111_000);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (obs() !== 8'b0_0000_100 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got %b in_ready %b expected %b in_ready 1", obs(), bus.in_ready, 8'b0_0000_100);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_nor();
    test_op7();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
- REQ-001: Parameter WIDTH, default 8, operand/result bit width; legal range 1..64.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: in_valid  input  1  operand set presented.
- REQ-005: in_ready  output  1  unit can accept operands this cycle (combinational).
- REQ-006: op  input  3  operation select, sampled with operands.
- REQ-007: a  input  WIDTH  operand A.
- REQ-008: b  input  WIDTH  operand B.
- REQ-009: acc_clr  input  1  accumulator clear request (used only when LOGIC_UNIT_ACC_EN is defined).
- REQ-010: out_valid  output  1  result registers hold an unconsumed result.
- REQ-011: out_ready  input  1  downstream accepts the result.
- REQ-012: y  output  WIDTH  registered result.
- REQ-013: zero  output  1  registered flag, y == 0.
- REQ-014: parity  output  1  registered flag, XOR-reduction of y.
- REQ-015: err  output  1  registered flag, result came from an illegal op.

Function
- REQ-016: Input transfer occurs on a rising edge when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
- REQ-017: in_ready = !out_valid || out_ready (one-deep pipeline with pass-through backpressure).
- REQ-018: Latency is 1 cycle: an input transfer at edge N drives y/zero/parity/err, with out_valid=1, after edge N.
- REQ-019: Throughput is one transfer per cycle while out_ready=1.
- REQ-020: With out_valid=1 and out_ready=0, y, zero, parity and err are held stable and no input is accepted.
- REQ-021: out_valid clears after an output transfer with no simultaneous input transfer, and stays 1 when both transfers happen on the same edge.
- REQ-022: op encoding: 000 a&b; 001 a|b; 010 a^b; 011 ~(a&b); 100 ~(a|b); 101 ~(a^b); 110 ~a (b ignored); 111 see REQ-027/REQ-028.
- REQ-023: All operations are bitwise over WIDTH bits; no carries or cross-bit effects except in the zero and parity flags.
- REQ-024: err=0 for ops 000..110.
- REQ-025: Inputs are ignored when in_valid=0 or in_ready=0; op, a and b need only be stable at the transfer edge.

Reset
- REQ-026: While rst=1, regardless of clk: out_valid=0, y=0, zero=1, parity=0, err=0, accumulator=all ones; in_ready then reads 1. Reset asserted mid-operation discards the held result.

Configuration
- REQ-027: With macro LOGIC_UNIT_ACC_EN defined, op 111 is ACC-AND: y = acc & a, err=0, and acc <= acc & a on the input transfer.
- REQ-028: With LOGIC_UNIT_ACC_EN defined, acc_clr=1 at an edge sets acc to all ones.
- REQ-029: If acc_clr=1 coincides with an op-111 transfer, y uses the old acc and acc_clr wins the update.
- REQ-030: Without LOGIC_UNIT_ACC_EN, no accumulator exists, acc_clr is ignored, and op 111 produces y=0, zero=1, parity=0, err=1.

Verification (WIDTH=4)
- REQ-031: Reset, then op=000 with a=1010, b=1100 for one cycle and out_ready=1 -> next cycle y=1000, out_valid=1, zero=0, parity=1, err=0.
- REQ-032: Back-to-back ops 001/010/011 on a=0101, b=1010 with out_ready=1 -> y=1111, 1111, 1111 on consecutive cycles; parity=0, zero=0.
- REQ-033: Result held with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, y stable, no input lost; first result taken when out_ready rises, then the pending input's result on the following cycle.
- REQ-034: op=100 with a=1111, b=0000 -> y=0000, zero=1, parity=0.
- REQ-035: ACC_EN defined: op 111 with a=1110 then a=0111 -> y=1110, then y=0110; acc_clr pulse, then a=0011 -> y=0011. ACC_EN undefined: op 111 -> y=0000, err=1.
- REQ-036: rst asserted asynchronously while out_valid=1 and out_ready=0 -> out_valid=0 and y=0000 before the next clk edge; in_ready=1.
